// File: rtl/alu_operand_entry_pkg.sv
// -----------------------------------------------------------------------------
// alu_entry_pkg
// Shared types and constants for the ALU operand entry front end.
//   entry_state_e : entry FSM state; its 2-bit encoding is also the value
//                   driven on the `stage` LED output.
//   OP_W          : opcode width.
//   STAGE_W       : width of the stage/state encoding.
//   next_stage()  : the fixed GET_A -> GET_B -> GET_OP -> DONE -> GET_A order.
// -----------------------------------------------------------------------------
package alu_entry_pkg;

    localparam int OP_W    = 3;
    localparam int STAGE_W = 2;

    typedef enum logic [STAGE_W-1:0] {
        GET_A  = 2'd0,
        GET_B  = 2'd1,
        GET_OP = 2'd2,
        DONE   = 2'd3
    } entry_state_e;

    // Every accepted press advances the entry position by one, wrapping at DONE.
    function automatic entry_state_e next_stage(input entry_state_e cur);
        entry_state_e nxt;
        case (cur)
            GET_A:   nxt = GET_B;
            GET_B:   nxt = GET_OP;
            GET_OP:  nxt = DONE;
            DONE:    nxt = GET_A;
            default: nxt = GET_A;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/alu_operand_entry_if.sv
// -----------------------------------------------------------------------------
// alu_operand_entry_if
// Board-side bundle of the operand entry block.
//   sw_data [W]    : operand switches
//   sw_op   [OP_W] : opcode switches
//   key_n          : raw active-low pushbutton
//   a_out/b_out[W] : latched operands
//   op_out  [OP_W] : latched opcode
//   valid          : one-cycle "operand set complete" pulse
//   stage   [2]    : current entry position for LEDs
// Modports:
//   slave  : the entry block (consumes switches/key, drives results)
//   master : the board/environment side (drives switches/key, reads results)
// -----------------------------------------------------------------------------
interface alu_operand_entry_if #(
    parameter int W = 8
);
    import alu_entry_pkg::*;

    logic [W-1:0]       sw_data;
    logic [OP_W-1:0]    sw_op;
    logic               key_n;
    logic [W-1:0]       a_out;
    logic [W-1:0]       b_out;
    logic [OP_W-1:0]    op_out;
    logic               valid;
    logic [STAGE_W-1:0] stage;

    modport slave (
        input  sw_data,
        input  sw_op,
        input  key_n,
        output a_out,
        output b_out,
        output op_out,
        output valid,
        output stage
    );

    modport master (
        output sw_data,
        output sw_op,
        output key_n,
        input  a_out,
        input  b_out,
        input  op_out,
        input  valid,
        input  stage
    );

endinterface

// File: rtl/alu_operand_entry_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Turns a raw, bouncy, asynchronous active-low pushbutton into a one-cycle
// `press` strobe.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   key_n  : raw pushbutton (0 = pressed)
//   press  : one-cycle strobe per accepted press; release produces nothing
// Build option ALU_OPERAND_ENTRY_DEBOUNCE_EN:
//   defined   : the accepted level only follows the synchronized key after
//               DEB_CYCLES consecutive differing cycles; press = accepted 1->0.
//   undefined : no filtering, press = falling edge of the synchronized key,
//               DEB_CYCLES has no effect.
// After reset, presses are suppressed until the key has been seen released,
// so a key held through reset release never counts as a press.
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    logic       sync1_r;
    logic       sync2_r;
    logic [1:0] warm_r;
    logic       armed_r;

    // Two-flop synchronizer; reset to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
        end
    end

    // Arm after reset: wait until the synchronizer holds real key samples
    // (two edges), then require one released observation before any press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_r  <= 2'd0;
            armed_r <= 1'b0;
        end else begin
            if (warm_r != 2'd2) begin
                warm_r  <= warm_r + 2'd1;
                armed_r <= armed_r;
            end else begin
                warm_r  <= warm_r;
                armed_r <= armed_r | sync2_r;
            end
        end
    end

`ifdef ALU_OPERAND_ENTRY_DEBOUNCE_EN

    localparam int              CNT_W    = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             flip_s;

    // The accepted level flips on the DEB_CYCLES-th consecutive differing cycle.
    assign flip_s = (sync2_r != level_r) && (cnt_r == CNT_LAST);

    // Debounce counter and accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= 1'b1;
        end else begin
            if (sync2_r == level_r) begin
                cnt_r   <= {CNT_W{1'b0}};
                level_r <= level_r;
            end else if (flip_s) begin
                cnt_r   <= {CNT_W{1'b0}};
                level_r <= sync2_r;
            end else begin
                cnt_r   <= cnt_r + CNT_W'(1);
                level_r <= level_r;
            end
        end
    end

    // Strobe in the cycle whose closing edge moves the accepted level 1 -> 0.
    assign press = armed_r & flip_s & level_r;

`else

    logic prev_r;

    // Previous synchronized level for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= sync2_r;
        end
    end

    assign press = armed_r & prev_r & ~sync2_r;

`endif

endmodule

// File: rtl/alu_operand_entry.sv
// -----------------------------------------------------------------------------
// alu_operand_entry
// Sequential operand entry for the 8-bit ALU: each accepted key press latches
// the switch bank into the next field (A, then B, then opcode). Latching the
// opcode raises `valid` for exactly one cycle; one more press wraps back to A.
// Ports:
//   clk    : system clock, all state on its rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : alu_operand_entry_if.slave (switches, key, a/b/op, valid, stage)
// Parameters:
//   W          : operand width
//   DEB_CYCLES : stable cycles needed to accept a key level (>= 2)
// Build option ALU_OPERAND_ENTRY_DEBOUNCE_EN selects the filtered key path;
// without it the key is only synchronized and edge-detected.
// -----------------------------------------------------------------------------
module alu_operand_entry
    import alu_entry_pkg::*;
#(
    parameter int W          = 8,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_operand_entry_if.slave   bus
);

    logic              press_s;
    entry_state_e      state_r;
    logic [W-1:0]      a_r;
    logic [W-1:0]      b_r;
    logic [OP_W-1:0]   op_r;
    logic              valid_r;

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_key_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (bus.key_n),
        .press (press_s)
    );

    // Entry FSM: capture into the field selected by the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= GET_A;
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            op_r    <= {OP_W{1'b0}};
            valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (press_s) begin
                case (state_r)
                    GET_A:   a_r <= bus.sw_data;
                    GET_B:   b_r <= bus.sw_data;
                    GET_OP: begin
                        op_r    <= bus.sw_op;
                        valid_r <= 1'b1;
                    end
                    DONE:    a_r <= a_r;
                    default: a_r <= a_r;
                endcase
                state_r <= next_stage(state_r);
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign bus.a_out  = a_r;
    assign bus.b_out  = b_r;
    assign bus.op_out = op_r;
    assign bus.valid  = valid_r;
    assign bus.stage  = state_r;

endmodule

// File: tb/tb_alu_operand_entry.sv
// Directed + randomized bench for alu_operand_entry with a behavioural model:
// the key is modelled as a history of per-edge samples; a press is derived
// from the key's accepted-level rules, and fields are filled in A/B/op order.
module tb_alu_operand_entry;
    import alu_entry_pkg::*;

    localparam int W   = 8;
    localparam int DEB = 4;
`ifdef ALU_OPERAND_ENTRY_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_operand_entry_if #(.W(W)) bus ();

    alu_operand_entry #(
        .W          (W),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit         hist[$];
    bit         acc;
    int         run;
    bit         armed;
    int         m_state;
    logic [7:0] m_a, m_b;
    logic [2:0] m_op;
    bit         m_valid;
    int         valid_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        acc = 1'b1; run = 0; armed = 1'b0;
        m_state = 0; m_a = 8'h00; m_b = 8'h00; m_op = 3'd0; m_valid = 1'b0;
    endtask

    // Key level the design can see at edge n (1-based since reset): the sample
    // taken two edges earlier, or "released" while the synchronizer refills.
    function automatic bit seen_at(input int n);
        if (n >= 3) return hist[n-3];
        return 1'b1;
    endfunction

    task automatic check_outputs();
        chk("a_out",  {24'd0, bus.a_out},  {24'd0, m_a});
        chk("b_out",  {24'd0, bus.b_out},  {24'd0, m_b});
        chk("op_out", {29'd0, bus.op_out}, {29'd0, m_op});
        chk("valid",  {31'd0, bus.valid},  {31'd0, m_valid});
        chk("stage",  {30'd0, bus.stage},  m_state);
    endtask

    // One clock: drive inputs, advance the model at the edge, compare after it.
    task automatic step(input bit k, input logic [7:0] d, input logic [2:0] o);
        bit s, ps, prs;
        int n;
        bus.key_n = k; bus.sw_data = d; bus.sw_op = o;
        @(posedge clk);
        hist.push_back(k);
        n   = hist.size();
        s   = seen_at(n);
        ps  = seen_at(n - 1);
        prs = 1'b0;
        if (DEB_EN) begin
            if (s != acc) begin
                run++;
                if (run == DEB) begin
                    acc = s;
                    run = 0;
                    prs = armed && !s;
                end
            end else begin
                run = 0;
            end
        end else begin
            prs = armed && ps && !s;
        end
        if (n >= 3 && s) armed = 1'b1;
        m_valid = 1'b0;
        if (prs) begin
            case (m_state)
                0: m_a = d;
                1: m_b = d;
                2: begin m_op = o; m_valid = 1'b1; end
                default: ;
            endcase
            m_state = (m_state + 1) % 4;
        end
        #1;
        if (bus.valid) valid_seen++;
        check_outputs();
    endtask

    // Clean press: key low then released, switches held constant.
    task automatic press_key(input logic [7:0] d, input logic [2:0] o);
        for (int i = 0; i < 10; i++) step(1'b0, d, o);
        for (int i = 0; i < 10; i++) step(1'b1, d, o);
    endtask

    initial begin
        logic [7:0] sa, sb;
        logic [2:0] so;
        int         st0, chg, first, prev;

        // Power-on reset.
        rst_n = 1'b0; bus.key_n = 1'b1; bus.sw_data = 8'h00; bus.sw_op = 3'd0;
        #12;
        chk("por_a", {24'd0, bus.a_out}, 32'd0);
        chk("por_stage", {30'd0, bus.stage}, 32'd0);
        chk("por_valid", {31'd0, bus.valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 3'($urandom));

        // Full sequence.
        press_key(8'h3C, 3'd7);
        press_key(8'hA5, 3'd1);
        valid_seen = 0;
        press_key(8'h11, 3'b010);
        chk("seq_a", {24'd0, bus.a_out}, 32'h3C);
        chk("seq_b", {24'd0, bus.b_out}, 32'hA5);
        chk("seq_op", {29'd0, bus.op_out}, 32'd2);
        chk("seq_stage", {30'd0, bus.stage}, 32'd3);
        chk("seq_valid_cycles", valid_seen, 32'd1);

        // Wrap from DONE back to GET_A, fields held.
        sa = bus.a_out; sb = bus.b_out; so = bus.op_out;
        press_key(8'h77, 3'd5);
        chk("wrap_stage", {30'd0, bus.stage}, 32'd0);
        chk("wrap_a", {24'd0, bus.a_out}, {24'd0, sa});
        chk("wrap_b", {24'd0, bus.b_out}, {24'd0, sb});
        chk("wrap_op", {29'd0, bus.op_out}, {29'd0, so});
        chk("wrap_valid", {31'd0, bus.valid}, 32'd0);
        press_key(8'hFF, 3'd0);
        chk("wrap_a_ff", {24'd0, bus.a_out}, 32'hFF);

        // Bounce: 2 low / 2 high for 20 cycles (5 falling edges), then high.
        st0 = bus.stage;
        for (int i = 0; i < 20; i++) step(((i / 2) % 2) != 0, 8'($urandom), 3'($urandom));
        for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 3'($urandom));
        chk("bounce_stage", {30'd0, bus.stage}, DEB_EN ? st0 : (st0 + 5) % 4);

        // Hold for 100 cycles: exactly one capture, at the expected latency.
        chg = 0; first = 0; prev = bus.stage;
        for (int i = 1; i <= 100; i++) begin
            step(1'b0, 8'($urandom), 3'($urandom));
            if (bus.stage != prev) begin
                chg++;
                if (first == 0) first = i;
            end
            prev = bus.stage;
        end
        for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 3'($urandom));
        chk("hold_captures", chg, 32'd1);
        chk("hold_latency", first, DEB_EN ? 32'(2 + DEB) : 32'd3);

        // Single-cycle glitch low.
        st0 = bus.stage;
        step(1'b0, 8'($urandom), 3'($urandom));
        for (int i = 0; i < 12; i++) step(1'b1, 8'($urandom), 3'($urandom));
        chk("glitch_stage", {30'd0, bus.stage}, DEB_EN ? st0 : (st0 + 1) % 4);

        // Randomized key activity with switches changing every cycle.
        for (int p = 0; p < 30; p++) begin
            int lo, hi;
            lo = $urandom_range(1, 12);
            hi = $urandom_range(1, 12);
            for (int i = 0; i < lo; i++) step(($urandom_range(0, 7) == 0), 8'($urandom), 3'($urandom));
            for (int i = 0; i < hi; i++) step(($urandom_range(0, 7) != 0), 8'($urandom), 3'($urandom));
        end
        for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 3'($urandom));

        // Reset in the middle of entry (GET_B) with the key held through release.
        for (int i = 0; i < 4 && m_state != 1; i++) press_key(8'($urandom), 3'($urandom));
        chk("pre_rst_stage", {30'd0, bus.stage}, 32'd1);
        #2;
        bus.key_n = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_a", {24'd0, bus.a_out}, 32'd0);
        chk("rst_b", {24'd0, bus.b_out}, 32'd0);
        chk("rst_op", {29'd0, bus.op_out}, 32'd0);
        chk("rst_valid", {31'd0, bus.valid}, 32'd0);
        chk("rst_stage", {30'd0, bus.stage}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 8'($urandom), 3'($urandom));
        chk("held_rst_stage", {30'd0, bus.stage}, 32'd0);
        chk("held_rst_a", {24'd0, bus.a_out}, 32'd0);
        for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 3'($urandom));
        press_key(8'h5A, 3'd3);
        chk("post_rst_a", {24'd0, bus.a_out}, 32'h5A);
        chk("post_rst_stage", {30'd0, bus.stage}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_entry.md
# alu_operand_entry

Sequential front end for the 8-bit ALU datapath: turns one debounced pushbutton plus the switch bank into registered operands A, B and opcode. Each accepted press latches the current switch value into the next field, A, then B, then op. After op is latched it issues a one-cycle `valid` pulse. It sits between the board switches/keys and the `alu` instance, replacing direct switch wiring so all 16 operand bits share the same switches.

## Interface
- `W`, 8: operand width; matches the ALU `w` parameter.
- `DEB_CYCLES`, 1000000: consecutive stable cycles required to accept a key level (20 ms at 50 MHz); minimum 2.
- `clk` in, 1: single system clock; all state on its rising edge.
- `rst_n` in, 1: reset, asynchronous assert, active-low.
- `sw_data` in, W: operand switches; treated as static during capture, not synchronized.
- `sw_op` in, 3: opcode switches.
- `key_n` in, 1: raw pushbutton, active-low, asynchronous and bouncy.
- `a_out` out, W: latched operand A.
- `b_out` out, W: latched operand B.
- `op_out` out, 3: latched opcode.
- `valid` out, 1: single-cycle pulse when a full operand set is complete.
- `stage` out, 2: current state encoding, for LED display.

## Operation
- Key path:
  - 2-FF synchronizer on `key_n`, reset value 1 (released).
  - Debouncer keeps an accepted level, reset 1. A counter counts cycles where the synchronized level differs from the accepted level and clears whenever they match. When the count reaches DEB_CYCLES-1, the accepted level flips and the counter clears.
  - `press` is a one-cycle strobe on an accepted 1->0 transition. Release generates nothing.
- FSM states, with `stage` encoding:
  - GET_A = 0. On press: `a_out` <= `sw_data`; go to GET_B.
  - GET_B = 1. On press: `b_out` <= `sw_data`; go to GET_OP.
  - GET_OP = 2. On press: `op_out` <= `sw_op`; `valid` <= 1; go to DONE.
  - DONE = 3. On press: go to GET_A. Registers are held until overwritten.
- With no press, state and registers hold. `valid` is 0 in every cycle except the one after the GET_OP capture.
- Holding the key down produces exactly one press. Bounce shorter than DEB_CYCLES produces none.
- Reset values: state GET_A, `a_out`=0, `b_out`=0, `op_out`=0, `valid`=0, `stage`=0. Debounce counter is 0 and the accepted level is 1.
- Reset mid-entry discards partial progress immediately; no press is generated on reset release, even if the key is held.

## Timing
- Key input to accepted press: 2 synchronizer cycles + DEB_CYCLES cycles of stable low.
- `press` to register update: 1 cycle. `a_out`/`b_out`/`op_out` and `stage` change on the edge that samples `press`.
- `valid` rises on that same edge, together with the `op_out` update, and is high for exactly one cycle.
- Outputs are registered; no combinational path from inputs to outputs.
- Minimum spacing between two presses: 2·DEB_CYCLES cycles (release, then press).

## Configuration
- `ALU_OPERAND_ENTRY_DEBOUNCE_EN` defined:
  - Debouncer present as described.
- Not defined:
  - Debouncer is bypassed. `press` is the falling edge of the synchronized key, with latency 2 cycles + 1 edge-detect cycle.
  - DEB_CYCLES is ignored.
  - Intended for simulation and for pre-cleaned key sources only.

## Structure
- Package `alu_entry_pkg`:
  - State enum (GET_A/GET_B/GET_OP/DONE) with its 2-bit encoding, which is also used for `stage`.
  - Opcode width constant, 3.
- Sub-module `key_debounce`:
  - Contains the synchronizer, debounce counter and press-edge strobe.
  - Parameter DEB_CYCLES; ports `clk`, `rst_n`, `key_n`, `press`.
  - The macro selects its body.
- The top-level FSM and registers stay in `alu_operand_entry`.

## Test plan
All tests use DEB_CYCLES=4 and the macro defined unless stated.
- Reset: assert `rst_n`=0 mid-GET_B -> all outputs 0 and `stage`=0 asynchronously. Key held through reset release -> no capture.
- Full sequence: `sw_data`=0x3C, press; 0xA5, press; `sw_op`=3'b010, press -> `a_out`=0x3C, `b_out`=0xA5, `op_out`=2, `valid` high exactly 1 cycle, `stage`=3.
- Bounce: toggle `key_n` low/high every 2 cycles for 20 cycles, then high -> no press, `stage` unchanged.
- Hold: key low for 100 cycles -> exactly one capture, first capture 2+4 cycles after the falling edge.
- Wrap: in DONE, press -> `stage`=0, `a_out`/`b_out`/`op_out` unchanged, `valid`=0. Next press with 0xFF -> `a_out`=0xFF.
- Macro undefined: single clean press -> capture after 3 cycles; a 1-cycle glitch low -> one press (no filtering).
